// File: rtl/mdu_pkg.sv
// Shared definitions for the RISC-V M-extension multiply/divide unit.
// Holds the funct3 operation encodings, the FSM state type and small op decoders.
package mdu_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_DONE = 2'b10
    } state_e;

    function automatic logic is_div(input mdu_op_e op);
        return op[2];
    endfunction

    function automatic logic is_rem(input mdu_op_e op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Restoring divider on unsigned magnitudes, one quotient bit per step.
// quo_c/rem_c expose the values the next step will register.
module mdu_div_core #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  step,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic [DATA_WIDTH-1:0] quo_c,
    output logic [DATA_WIDTH-1:0] rem_c
);

    localparam int unsigned W = DATA_WIDTH;

    logic [W-1:0] quo_q;
    logic [W-1:0] rem_q;
    logic [W-1:0] dsor_q;
    logic [W:0]   shifted;
    logic [W:0]   diff;
    logic         fits;

    // Shift in the next dividend bit and try to subtract the divisor.
    always_comb begin
        shifted = {rem_q, quo_q[W-1]};
        diff    = shifted - {1'b0, dsor_q};
        fits    = ~diff[W];
        quo_c   = {quo_q[W-2:0], fits};
        rem_c   = fits ? diff[W-1:0] : shifted[W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quo_q  <= '0;
            rem_q  <= '0;
            dsor_q <= '0;
        end else if (start) begin
            quo_q  <= dividend;
            rem_q  <= '0;
            dsor_q <= divisor;
        end else if (step) begin
            quo_q  <= quo_c;
            rem_q  <= rem_c;
        end
    end

endmodule

// File: rtl/mdu_riscv.sv
// Iterative RISC-V M-extension multiply/divide unit with valid/ready handshakes.
// Macro MDU_DIV_EN enables the divider; without it div/rem complete as divide-by-zero.
module mdu_riscv
    import mdu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic [2:0]            MDUop,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] Result,
    output logic                  Zero,
    output logic                  DivByZero
);

    localparam int unsigned W     = DATA_WIDTH;
    localparam int unsigned PW    = 2 * DATA_WIDTH;
    localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

    state_e           state_q, state_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    mdu_op_e          op_q, op_n;
    logic             neg_q, neg_n;
    logic [W-1:0]     mcand_q, mcand_n;
    logic [PW-1:0]    prod_q, prod_n;
    logic [W-1:0]     result_q, result_n;
    logic             dbz_q, dbz_n;

    mdu_op_e          op_in;
    logic             a_neg, b_neg;
    logic [W-1:0]     a_mag, b_mag;
    logic [W-1:0]     addend;
    logic [W:0]       mul_sum;
    logic [PW-1:0]    prod_step, prod_fin;

    // Signed operands are processed as magnitudes; the sign is restored at the end.
    always_comb begin
        op_in = mdu_op_e'(MDUop);
        a_neg = A[W-1] && (op_in inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
        b_neg = B[W-1] && (op_in inside {OP_MUL, OP_MULH, OP_DIV, OP_REM});
        a_mag = a_neg ? (~A + W'(1)) : A;
        b_mag = b_neg ? (~B + W'(1)) : B;
    end

    // Shift-add step: multiplier sits in the low half and shifts out as the product grows.
    always_comb begin
        addend    = prod_q[0] ? mcand_q : '0;
        mul_sum   = {1'b0, prod_q[PW-1:W]} + {1'b0, addend};
        prod_step = {mul_sum, prod_q[W-1:1]};
        prod_fin  = neg_q ? (~prod_step + PW'(1)) : prod_step;
    end

`ifdef MDU_DIV_EN
    logic         neg_rem_q, neg_rem_n;
    logic         div_start;
    logic         div_step;
    logic [W-1:0] quo_c, rem_c;
    logic [W-1:0] quo_fin, rem_fin;

    assign div_step = (state_q == S_CALC) && is_div(op_q);
    assign quo_fin  = neg_q ? (~quo_c + W'(1)) : quo_c;
    assign rem_fin  = neg_rem_q ? (~rem_c + W'(1)) : rem_c;

    mdu_div_core #(
        .DATA_WIDTH(W)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .step     (div_step),
        .dividend (a_mag),
        .divisor  (b_mag),
        .quo_c    (quo_c),
        .rem_c    (rem_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) neg_rem_q <= 1'b0;
        else        neg_rem_q <= neg_rem_n;
    end
`endif

    always_comb begin
        state_n  = state_q;
        cnt_n    = cnt_q;
        op_n     = op_q;
        neg_n    = neg_q;
        mcand_n  = mcand_q;
        prod_n   = prod_q;
        result_n = result_q;
        dbz_n    = dbz_q;
`ifdef MDU_DIV_EN
        neg_rem_n = neg_rem_q;
        div_start = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_n  = op_in;
                    neg_n = a_neg ^ b_neg;
                    dbz_n = 1'b0;
                    if (is_div(op_in)) begin
`ifdef MDU_DIV_EN
                        neg_rem_n = a_neg;
                        if (B == '0) begin
                            state_n  = S_DONE;
                            result_n = is_rem(op_in) ? A : '1;
                            dbz_n    = 1'b1;
                        end else if ((op_in inside {OP_DIV, OP_REM}) && (A == MOST_NEG) && (B == '1)) begin
                            state_n  = S_DONE;
                            result_n = (op_in == OP_DIV) ? A : '0;
                        end else begin
                            state_n   = S_CALC;
                            cnt_n     = CNT_W'(W);
                            div_start = 1'b1;
                        end
`else
                        state_n  = S_DONE;
                        result_n = is_rem(op_in) ? A : '1;
                        dbz_n    = 1'b1;
`endif
                    end else begin
                        state_n = S_CALC;
                        cnt_n   = CNT_W'(W);
                        mcand_n = a_mag;
                        prod_n  = {{W{1'b0}}, b_mag};
                    end
                end
            end
            S_CALC: begin
                cnt_n  = cnt_q - CNT_W'(1);
                prod_n = prod_step;
                // Last bit: finish on the edge that drains the counter.
                if (cnt_q == CNT_W'(1)) begin
                    state_n  = S_DONE;
                    result_n = (op_q == OP_MUL) ? prod_fin[W-1:0] : prod_fin[PW-1:W];
`ifdef MDU_DIV_EN
                    if (is_div(op_q)) result_n = is_rem(op_q) ? rem_fin : quo_fin;
`endif
                end
            end
            S_DONE: begin
                if (out_ready) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= OP_MUL;
            neg_q    <= 1'b0;
            mcand_q  <= '0;
            prod_q   <= '0;
            result_q <= '0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_n;
            cnt_q    <= cnt_n;
            op_q     <= op_n;
            neg_q    <= neg_n;
            mcand_q  <= mcand_n;
            prod_q   <= prod_n;
            result_q <= result_n;
            dbz_q    <= dbz_n;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign Result    = result_q;
    assign DivByZero = dbz_q;
    assign Zero      = (result_q == '0);

endmodule

// File: tb/tb_mdu_riscv.sv
// Scoreboard bench for mdu_riscv: driver pushes reference results, monitor checks outputs.
// Reference model follows MDU_DIV_EN the same way the design build does.
module tb_mdu_riscv;
    import mdu_pkg::*;

    localparam int unsigned W = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  A = '0;
    logic [W-1:0]  B = '0;
    logic [2:0]    MDUop = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  Result;
    logic          Zero;
    logic          DivByZero;

    typedef struct {
        logic [31:0] res;
        logic        dbz;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic prev_v = 1'b0;
    logic bp_hold = 1'b0;
    logic bp_rand = 1'b0;

    mdu_riscv #(.DATA_WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .MDUop     (MDUop),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Result    (Result),
        .Zero      (Zero),
        .DivByZero (DivByZero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        out_ready = bp_hold ? 1'b0 : (bp_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the architectural definitions.
    function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      sa, sbv, ub;
        logic [63:0] p;
        sa  = $signed(a);
        sbv = $signed(b);
        ub  = longint'({32'h0, b});
        e.dbz = 1'b0;
        e.lat = W + 1;
        e.acc = 0;
        e.res = '0;
        case (op)
            3'd0: begin p = 64'(sa * sbv); e.res = p[31:0];  end
            3'd1: begin p = 64'(sa * sbv); e.res = p[63:32]; end
            3'd2: begin p = 64'(sa * ub);  e.res = p[63:32]; end
            3'd3: begin p = {32'h0, a} * {32'h0, b}; e.res = p[63:32]; end
            default: begin
`ifdef MDU_DIV_EN
                if (b == 32'h0) begin
                    e.res = op[1] ? a : 32'hFFFF_FFFF;
                    e.dbz = 1'b1;
                    e.lat = 1;
                end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    e.res = op[1] ? 32'h0 : a;
                    e.lat = 1;
                end else begin
                    case (op)
                        3'd4:    e.res = 32'(sa / sbv);
                        3'd5:    e.res = a / b;
                        3'd6:    e.res = 32'(sa % sbv);
                        default: e.res = a % b;
                    endcase
                end
`else
                e.res = op[1] ? a : 32'hFFFF_FFFF;
                e.dbz = 1'b1;
                e.lat = 1;
`endif
            end
        endcase
        return e;
    endfunction

    // Called at posedge+1; waits for in_ready, presents one request for one edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            chk("issue_in_ready_timeout", {31'b0, in_ready}, 32'd1);
            return;
        end
        e = model(op, a, b);
        e.acc = cyc + 1;
        sb.push_back(e);
        in_valid = 1'b1;
        MDUop    = op;
        A        = a;
        B        = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        A        = $urandom;
        B        = $urandom;
        MDUop    = 3'($urandom_range(0, 7));
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || out_valid) && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb.size() != 0 || out_valid) begin
            chk("drain_pending", 32'(sb.size()) | {31'b0, out_valid}, 32'd0);
            sb.delete();
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: latency on the rising edge of out_valid, payload on the handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v = 1'b0;
        end else begin
            if (out_valid && !prev_v) begin
                if (sb.size() == 0) chk("unexpected_out_valid", 32'd1, 32'd0);
                else chk("latency", 32'(cyc - sb[0].acc + 1), 32'(sb[0].lat));
            end
            if (out_valid && out_ready && sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("result", Result, e.res);
                chk("div_by_zero", {31'b0, DivByZero}, {31'b0, e.dbz});
                chk("zero_flag", {31'b0, Zero}, {31'b0, (e.res == 32'h0)});
            end
            prev_v = out_valid;
        end
    end

    initial begin
        exp_t e;
        int   n;
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_result", Result, 32'h0);
        chk("rst_zero", {31'b0, Zero}, 32'd1);
        chk("rst_dbz", {31'b0, DivByZero}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed corner cases.
        issue(OP_MULH,  32'hFFFF_FFFF, 32'h0000_0002); drain();
        issue(OP_MULHU, 32'hFFFF_FFFF, 32'h0000_0002); drain();
        issue(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002); drain();
        issue(OP_REM,   32'hFFFF_FFF9, 32'h0000_0002); drain();
        issue(OP_DIVU,  32'h0000_0007, 32'h0000_0000); drain();
        issue(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF); drain();
        issue(OP_REM,   32'h8000_0000, 32'hFFFF_FFFF); drain();
        issue(OP_DIVU,  32'h0000_000A, 32'h0000_0002); drain();
        issue(OP_MUL,   32'h8000_0000, 32'h8000_0000); drain();
        issue(OP_MULHSU,32'h8000_0000, 32'hFFFF_FFFF); drain();

        // Backpressure: result held, no accept, input pulses ignored.
        bp_rand = 1'b0;
        bp_hold = 1'b1;
        @(posedge clk); #1;
        e = model(OP_MULHU, 32'hDEAD_BEEF, 32'h1234_5678);
        issue(OP_MULHU, 32'hDEAD_BEEF, 32'h1234_5678);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp_out_valid_seen", {31'b0, out_valid}, 32'd1);
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            A        = $urandom;
            B        = 32'h0;
            MDUop    = 3'd5;
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk("bp_result_stable", Result, e.res);
            chk("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
            chk("bp_out_valid_held", {31'b0, out_valid}, 32'd1);
        end
        bp_hold = 1'b0;
        drain();

        // Reset ten cycles into a multiply.
        issue(OP_MUL, $urandom, $urandom);
        repeat (9) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_result", Result, 32'h0);
        chk("midrst_zero", {31'b0, Zero}, 32'd1);
        chk("midrst_dbz", {31'b0, DivByZero}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("postrst_in_ready", {31'b0, in_ready}, 32'd1);
        issue(OP_MUL, 32'd3, 32'd5);
        drain();

        // Random traffic with random consumer stalls.
        bp_rand = 1'b1;
        for (int i = 0; i < 150; i++) begin
            issue(3'($urandom_range(0, 7)), pick(), pick());
        end
        drain();
        bp_rand = 1'b0;
        @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
